// File: rtl/mode_switch_sequencer_if.sv
// Bus between the configuration decoder, the mode sequencer and the PLL/timing-generator side.
// The slave modport is the sequencer's view; the master modport is the view of whatever drives it.
interface mode_switch_sequencer_if;
   logic [7:0] config_data;
   logic       config_changed;
   logic       pll_locked;
   logic [7:0] active_mode;
   logic       mode_change;
   logic       pll_areset;
   logic       video_reset;
   logic       mode_valid;
   logic       lock_error;

   modport slave (
      input  config_data, config_changed, pll_locked,
      output active_mode, mode_change, pll_areset, video_reset, mode_valid, lock_error
   );

   modport master (
      output config_data, config_changed, pll_locked,
      input  active_mode, mode_change, pll_areset, video_reset, mode_valid, lock_error
   );
endinterface

// File: rtl/mode_switch_sequencer.sv
// Debounces the decoded video mode, commits it to active_mode, then sequences the PLL reset,
// waits for a stable lock and releases the timing generator. It retries on lock timeout or lock loss.
module mode_switch_sequencer #(
   parameter logic [15:0] DEBOUNCE_CYCLES     = 16'd50000,
   parameter logic [15:0] RESET_HOLD_CYCLES   = 16'd64,
   parameter logic [15:0] LOCK_STABLE_CYCLES  = 16'd256,
   parameter logic [23:0] LOCK_TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   mode_switch_sequencer_if.slave bus
);
   localparam logic [15:0] DEB_LAST    = DEBOUNCE_CYCLES - 16'd1;
   localparam logic [15:0] HOLD_LAST   = RESET_HOLD_CYCLES - 16'd1;
   localparam logic [15:0] STABLE_LAST = LOCK_STABLE_CYCLES - 16'd1;
   localparam logic [23:0] TMO_LAST    = LOCK_TIMEOUT_CYCLES - 24'd1;

   typedef enum logic [1:0] {DEBOUNCE, APPLY, WAIT_LOCK, RUN} state_t;

   state_t      state;
   logic [7:0]  candidate;
   logic        first;
   logic [15:0] deb_cnt;
   logic [15:0] hold_cnt;
   logic [15:0] stable_cnt;
   logic [23:0] tmo_cnt;

   logic [7:0]  active_mode;
   logic        mode_change;
   logic        pll_areset;
   logic        video_reset;
   logic        mode_valid;
   logic        lock_error;

   assign bus.active_mode = active_mode;
   assign bus.mode_change = mode_change;
   assign bus.pll_areset  = pll_areset;
   assign bus.video_reset = video_reset;
   assign bus.mode_valid  = mode_valid;
   assign bus.lock_error  = lock_error;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= DEBOUNCE;
         candidate   <= '0;
         first       <= 1'b1;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         stable_cnt  <= '0;
         tmo_cnt     <= '0;
         active_mode <= '0;
         mode_change <= 1'b0;
         pll_areset  <= 1'b1;
         video_reset <= 1'b1;
         mode_valid  <= 1'b0;
         lock_error  <= 1'b0;
      end else begin
         mode_change <= 1'b0;
         case (state)
            DEBOUNCE: begin
               if (first || bus.config_changed || (bus.config_data != candidate)) begin
                  candidate <= bus.config_data;
                  deb_cnt   <= '0;
                  first     <= 1'b0;
               end else if (deb_cnt == DEB_LAST) begin
                  // A glitch that settles back on the running mode returns without touching the pipeline
                  if (mode_valid && (candidate == active_mode)) begin
                     state <= RUN;
                  end else begin
                     state       <= APPLY;
                     active_mode <= candidate;
                     mode_change <= 1'b1;
                     pll_areset  <= 1'b1;
                     video_reset <= 1'b1;
                     mode_valid  <= 1'b0;
                     hold_cnt    <= '0;
                  end
               end else begin
                  deb_cnt <= deb_cnt + 16'd1;
               end
            end

            APPLY: begin
               if (hold_cnt == HOLD_LAST) begin
                  state      <= WAIT_LOCK;
                  pll_areset <= 1'b0;
                  stable_cnt <= '0;
                  tmo_cnt    <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 16'd1;
               end
            end

            WAIT_LOCK: begin
               // Lock is tested before timeout so a lock on the last allowed cycle still wins
               if (bus.pll_locked && (stable_cnt == STABLE_LAST)) begin
                  state       <= RUN;
                  video_reset <= 1'b0;
                  mode_valid  <= 1'b1;
                  lock_error  <= 1'b0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state       <= APPLY;
                  lock_error  <= 1'b1;
                  active_mode <= candidate;
                  mode_change <= 1'b1;
                  pll_areset  <= 1'b1;
                  video_reset <= 1'b1;
                  mode_valid  <= 1'b0;
                  hold_cnt    <= '0;
               end else begin
                  tmo_cnt    <= tmo_cnt + 24'd1;
                  stable_cnt <= bus.pll_locked ? (stable_cnt + 16'd1) : '0;
               end
            end

            RUN: begin
               if (!bus.pll_locked) begin
                  state       <= APPLY;
                  lock_error  <= 1'b1;
                  active_mode <= candidate;
                  mode_change <= 1'b1;
                  pll_areset  <= 1'b1;
                  video_reset <= 1'b1;
                  mode_valid  <= 1'b0;
                  hold_cnt    <= '0;
               end else if (bus.config_changed || (bus.config_data != active_mode)) begin
                  state     <= DEBOUNCE;
                  candidate <= bus.config_data;
                  deb_cnt   <= '0;
               end
            end

            default: state <= DEBOUNCE;
         endcase
      end
   end
endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Randomized scoreboard bench: stimulus predicts output events with cycle stamps from the
// sequencing rules; a negedge monitor pops and compares each event as the sequencer produces it.
module tb_mode_switch_sequencer;
   localparam int DEB  = 8;
   localparam int HOLD = 4;
   localparam int LS   = 2;
   localparam int LT   = 32;

   typedef enum int {EV_CHANGE, EV_AREL, EV_RUN} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      int         cyc;
      logic [7:0] mode;
      logic       lerr;
   } ev_t;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   int         cyc     = 0;
   int         checks  = 0;
   int         passes  = 0;
   ev_t        exp_q[$];
   logic [7:0] prev_cfg = 8'h00;
   logic [7:0] cur_mode = 8'h00;

   mode_switch_sequencer_if bus();

   mode_switch_sequencer #(
      .DEBOUNCE_CYCLES    (16'd8),
      .RESET_HOLD_CYCLES  (16'd4),
      .LOCK_STABLE_CYCLES (16'd2),
      .LOCK_TIMEOUT_CYCLES(24'd32)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Configuration decoder stand-in: flags a value that differs from last cycle's
   always @(posedge clock) prev_cfg <= bus.config_data;
   assign bus.config_changed = (bus.config_data != prev_cfg);

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input ev_kind_t k, input int c, input logic [7:0] m, input logic le);
      ev_t e;
      e.kind = k; e.cyc = c; e.mode = m; e.lerr = le;
      exp_q.push_back(e);
   endtask

   task automatic match(input ev_kind_t k);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.cyc);
      case (k)
         EV_CHANGE: begin
            check("change_active_mode", bus.active_mode, e.mode);
            check("change_pll_areset", bus.pll_areset, 1);
            check("change_video_reset", bus.video_reset, 1);
            check("change_mode_valid", bus.mode_valid, 0);
            check("change_lock_error", bus.lock_error, e.lerr);
         end
         EV_AREL: begin
            check("arel_video_reset", bus.video_reset, 1);
            check("arel_mode_valid", bus.mode_valid, 0);
            check("arel_lock_error", bus.lock_error, e.lerr);
         end
         default: begin
            check("run_active_mode", bus.active_mode, e.mode);
            check("run_video_reset", bus.video_reset, 0);
            check("run_pll_areset", bus.pll_areset, 0);
            check("run_lock_error", bus.lock_error, e.lerr);
         end
      endcase
   endtask

   logic p_mc = 1'b0, p_mv = 1'b0, p_ar = 1'b1;
   always @(negedge clock) begin
      if (!reset_n) begin
         p_mc <= 1'b0; p_mv <= 1'b0; p_ar <= 1'b1;
      end else begin
         if (p_mc) check("mode_change_width", bus.mode_change, 0);
         if (p_mv && !bus.mode_valid) check("mode_valid_fall_with_change", bus.mode_change, 1);
         if (bus.mode_change && !p_mc) match(EV_CHANGE);
         if (!bus.pll_areset && p_ar) match(EV_AREL);
         if (bus.mode_valid && !p_mv) match(EV_RUN);
         p_mc <= bus.mode_change; p_mv <= bus.mode_valid; p_ar <= bus.pll_areset;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   function automatic logic [7:0] new_mode();
      logic [7:0] v;
      do v = 8'($urandom_range(1, 255)); while (v == cur_mode);
      return v;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_active_mode"}, bus.active_mode, 0);
      check({tag, "_mode_change"}, bus.mode_change, 0);
      check({tag, "_pll_areset"}, bus.pll_areset, 1);
      check({tag, "_video_reset"}, bus.video_reset, 1);
      check({tag, "_mode_valid"}, bus.mode_valid, 0);
      check({tag, "_lock_error"}, bus.lock_error, 0);
   endtask

   // First active edge after release loads the candidate; commit follows DEB edges later
   task automatic release_reset(input logic [7:0] m);
      int a;
      bus.config_data = m;
      bus.pll_locked  = 1'b1;
      reset_n = 1'b1;
      cur_mode = m;
      a = cyc + 1 + DEB;
      push(EV_CHANGE, a, m, 1'b0);
      push(EV_AREL, a + HOLD, m, 1'b0);
      push(EV_RUN, a + HOLD + LS, m, 1'b0);
      wait_until(a + HOLD + LS + 2);
      check("powerup_mode_valid", bus.mode_valid, 1);
   endtask

   task automatic glitch(input logic [7:0] g, input int len);
      int c2;
      bus.config_data = g;
      step(len);
      bus.config_data = cur_mode;
      c2 = cyc;
      step(2);
      check("glitch_mode_valid", bus.mode_valid, 1);
      check("glitch_video_reset", bus.video_reset, 0);
      wait_until(c2 + 1 + DEB + 2);
      check("glitch_active_mode", bus.active_mode, cur_mode);
      check("glitch_after_mode_valid", bus.mode_valid, 1);
   endtask

   task automatic mode_change_seq(input logic [7:0] v, input bit drop_lock, input int lock_off);
      int c, a, w2;
      bus.config_data = v;
      c = cyc;
      a = c + 1 + DEB;
      cur_mode = v;
      push(EV_CHANGE, a, v, 1'b0);
      push(EV_AREL, a + HOLD, v, 1'b0);
      step(2);
      check("debounce_video_reset", bus.video_reset, 0);
      check("debounce_mode_valid", bus.mode_valid, 1);
      if (!drop_lock) begin
         push(EV_RUN, a + HOLD + LS, v, 1'b0);
         wait_until(a + HOLD + LS + 2);
      end else begin
         bus.pll_locked = 1'b0;
         push(EV_CHANGE, a + HOLD + LT, v, 1'b1);
         w2 = a + HOLD + LT + HOLD;
         push(EV_AREL, w2, v, 1'b1);
         wait_until(w2 + lock_off);
         bus.pll_locked = 1'b1;
         push(EV_RUN, w2 + lock_off + 2, v, 1'b0);
         wait_until(w2 + lock_off + 4);
      end
   endtask

   task automatic lock_loss();
      int c;
      bus.pll_locked = 1'b0;
      c = cyc;
      push(EV_CHANGE, c + 1, cur_mode, 1'b1);
      push(EV_AREL, c + 1 + HOLD, cur_mode, 1'b1);
      push(EV_RUN, c + 1 + HOLD + LS, cur_mode, 1'b0);
      step(1);
      bus.pll_locked = 1'b1;
      wait_until(c + 1 + HOLD + LS + 2);
   endtask

   task automatic reset_in_wait_lock();
      logic [7:0] v;
      int a;
      v = new_mode();
      bus.config_data = v;
      a = cyc + 1 + DEB;
      push(EV_CHANGE, a, v, 1'b0);
      push(EV_AREL, a + HOLD, v, 1'b0);
      step(2);
      bus.pll_locked = 1'b0;
      wait_until(a + HOLD + 5);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      step(3);
      release_reset(new_mode());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int pick;
      bus.config_data = 8'h01;
      bus.pll_locked  = 1'b1;
      repeat (3) @(posedge clock);
      #2;
      check_reset_values("reset");
      step(1);

      release_reset(8'h01);
      glitch(8'h04, 3);
      lock_loss();
      mode_change_seq(8'h08, 1'b0, 0);
      mode_change_seq(new_mode(), 1'b1, int'($urandom_range(0, LT - 3)));
      mode_change_seq(new_mode(), 1'b1, LT - 2);
      lock_loss();
      reset_in_wait_lock();

      for (int i = 0; i < 8; i++) begin
         pick = int'($urandom_range(0, 3));
         case (pick)
            0: glitch(new_mode(), int'($urandom_range(1, DEB - 2)));
            1: mode_change_seq(new_mode(), 1'b0, 0);
            2: mode_change_seq(new_mode(), 1'b1, int'($urandom_range(0, LT - 2)));
            default: lock_loss();
         endcase
      end

      step(5);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mode_switch_sequencer.md
Name: mode_switch_sequencer

Overview:
- Sequences video mode changes from the `configuration` block's `config_data`/`config_changed` outputs.
- Debounces the selected mode, then commits it to `active_mode`.
- Holds the video PLL and timing generator in reset, waits for a stable PLL lock, then releases the video pipeline.
- Sits between the DIP-switch configuration decoder and the PLL/timing generator. It is the only source of `active_mode` for downstream logic.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive cycles `config_data` must hold one value before it is committed.
- RESET_HOLD_CYCLES, 16'd64: cycles `pll_areset` is held high in APPLY.
- LOCK_STABLE_CYCLES, 16'd256: consecutive cycles with `pll_locked` high needed to declare lock.
- LOCK_TIMEOUT_CYCLES, 24'd1000000: maximum cycles in WAIT_LOCK before retry.

Ports:
- clock  in  1  system clock, sole clock domain
- reset_n  in  1  asynchronous, active-low reset
- config_data  in  8  decoded mode code from configuration decoder
- config_changed  in  1  high when config_data differs from its previous-cycle value
- pll_locked  in  1  video PLL lock, already synchronised to clock
- active_mode  out  8  committed mode code
- mode_change  out  1  one-cycle pulse when active_mode is loaded
- pll_areset  out  1  PLL reset, active high
- video_reset  out  1  timing-generator reset, active high
- mode_valid  out  1  high when video pipeline is running in active_mode
- lock_error  out  1  sticky until next RUN entry: a lock timeout or lock loss occurred

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset_n); all flops clear immediately on reset_n low.
- States: DEBOUNCE, APPLY, WAIT_LOCK, RUN. All outputs are registered.
- Reset values:
  - state = DEBOUNCE, candidate = 8'h00, counters = 0, first = 1.
  - active_mode = 8'h00, mode_change = 0, pll_areset = 1, video_reset = 1, mode_valid = 0, lock_error = 0.
- DEBOUNCE:
  - If first, or config_data != candidate, or config_changed: candidate <= config_data, cnt <= 0, first <= 0.
  - Otherwise cnt increments.
  - Exit on a cycle where cnt == DEBOUNCE_CYCLES-1 and config_data == candidate with config_changed low:
    - If mode_valid=1 and candidate == active_mode: go to RUN, outputs unchanged (glitch rejected, no reset).
    - Otherwise go to APPLY.
  - pll_areset, video_reset and mode_valid keep their values while in DEBOUNCE. A running pipeline keeps running during debounce.
- APPLY:
  - On entry: active_mode <= candidate, mode_change = 1 for exactly that cycle.
  - pll_areset = 1, video_reset = 1, mode_valid = 0.
  - Stay RESET_HOLD_CYCLES cycles, then go to WAIT_LOCK.
  - Retry entries from WAIT_LOCK/RUN reload active_mode with its same value and still pulse mode_change.
- WAIT_LOCK:
  - pll_areset = 0, video_reset = 1.
  - stable_cnt increments while pll_locked=1 and clears when pll_locked=0.
  - tmo_cnt increments every cycle.
  - stable_cnt reaching LOCK_STABLE_CYCLES-1 with pll_locked=1: go to RUN.
  - Else tmo_cnt reaching LOCK_TIMEOUT_CYCLES-1: lock_error <= 1, go to APPLY.
  - If both conditions hit in the same cycle, lock wins.
- RUN:
  - On entry: video_reset <= 0, mode_valid <= 1, lock_error <= 0. Exception: the glitch-return path leaves lock_error unchanged.
  - Priority 1, pll_locked=0: lock_error <= 1, mode_valid <= 0, video_reset <= 1, go to APPLY.
  - Priority 2, config_changed or config_data != active_mode: go to DEBOUNCE with cnt cleared and candidate <= config_data.
- Reset mid-operation:
  - Returns everything to reset values immediately.
  - The full debounce → apply → lock sequence reruns.
- Counter widths: counters are sized to their parameter. Counters never wrap, because exit occurs at terminal count.

Test Plan (DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=2, LOCK_TIMEOUT_CYCLES=32):
1. Power-up: release reset_n with config_data=8'h01 constant and pll_locked=1 -> mode_change pulses and active_mode=8'h01 on the cycle after 8 stable DEBOUNCE cycles; pll_areset falls 4 cycles later; mode_valid=1 and video_reset=0 2 cycles after that.
2. Glitch: in RUN, config_data 01→04 for 3 cycles, then back to 01 -> no mode_change, mode_valid stays 1, return to RUN after 8 stable cycles.
3. Mode change: in RUN, config_data becomes 8'h08 and holds -> video_reset stays 0 for the 8 debounce cycles; then active_mode=8'h08, mode_change pulse, mode_valid=0, pll_areset=1 for 4 cycles; relock with pll_locked=1 -> RUN.
4. Lock timeout: pll_locked held 0 in WAIT_LOCK -> after 32 cycles lock_error=1, pll_areset reasserted for 4 cycles; raise pll_locked -> RUN, lock_error clears.
5. Lock loss: drop pll_locked for 1 cycle in RUN -> next cycle mode_valid=0, video_reset=1, lock_error=1, APPLY with mode_change pulse and same active_mode.
6. Async reset: assert reset_n low during WAIT_LOCK -> outputs immediately at reset values; sequence restarts from DEBOUNCE.
